inst_mem_loader: RTL
====================

Name: inst_mem_loader

Overview:
- Writer side of the processor's program memory: receives a byte stream from a host, packs bytes into 32-bit instruction words and writes them into a 16x32 instruction memory.
- The processor fetches from this memory through an asynchronous read port.
- Holds the processor in reset until a complete, checksum-verified program has been loaded.
- Replaces the file-based memory preload for in-system reprogramming.

Parameters:
- DEPTH, 16, number of instruction words.
- AW, 4, address width (log2 DEPTH).
- IW, 32, instruction width.
- BPW, 4, bytes per instruction word (IW/8).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a load session.
- in_valid  input  1  host byte valid.
- in_data  input  8  host byte.
- in_ready  output  1  loader can accept a byte this cycle.
- rd_addr  input  AW  processor fetch address (pc).
- rd_data  output  IW  mem[rd_addr], combinational.
- cpu_rst  output  1  reset to the processor; high except in DONE.
- load_done  output  1  program loaded and verified.
- load_err  output  1  sticky error (bad header or checksum).
- words_loaded  output  AW+1  number of words written in the current session.

Behaviour:
- Reset (async): state=IDLE; in_ready=0, cpu_rst=1, load_done=0, load_err=0, words_loaded=0; internal byte index, word counter and checksum cleared. Memory contents are not reset.
- A byte is accepted on a rising edge with in_valid & in_ready. in_ready=1 only in HDR, DATA and CSUM. in_ready is a function of state only and does not depend on in_valid.
- States:
  - IDLE: start -> HDR; load_err cleared.
  - HDR: accepted byte = N.
    - N==0 or N>DEPTH -> ERR.
    - Otherwise latch N; clear addr, byte_idx, csum, words_loaded -> DATA.
  - DATA: bytes arrive MSB first; shift register updated; csum ^= byte.
    - On the BPW-th byte: mem[addr] <= {shift[23:0], byte} on that same edge (1-cycle write latency); words_loaded++, addr++, byte_idx=0.
    - If this was word N -> CSUM.
  - CSUM: accepted byte compared with the running XOR of all data bytes; equal -> DONE, else -> ERR.
  - DONE: load_done=1, cpu_rst=0; start -> HDR (load_done=0, cpu_rst=1 from the next cycle).
  - ERR: load_err=1, cpu_rst=1; start -> HDR with load_err cleared.
- start is ignored in HDR, DATA and CSUM; an in-progress load cannot be aborted except by rst.
- A start in DONE coincident with in_valid: start wins; the byte is not accepted (in_ready=0 in DONE).
- Gaps in in_valid are allowed anywhere; state and partial word are held.
- rst mid-load: immediate return to IDLE. Words already written stay in memory; the partial word is discarded.
- rd_data is valid in every state, including during a load (read-during-write returns old data until the write edge). The processor is in reset in all states except DONE.
- cpu_rst is a registered output, so it deasserts no earlier than one cycle after the CSUM byte is accepted.

Decomposition:
- Shared package inst_loader_pkg holds:
  - state encoding (IDLE, HDR, DATA, CSUM, DONE, ERR);
  - DEPTH/AW/IW/BPW defaults;
  - the instruction field positions already used by the processor (op_type 31:27, rdst 26:22, rsrc1 21:17, mode 16, rsrc2 15:11, isrc 15:0), for bench decoding.
- One sub-module, loader_word_assembler: byte shift register, byte_idx counter and XOR checksum, emitting word_valid/word. The FSM and memory stay in the top.

Test Plan:
- start; bytes 01, 08, 41, 00, 05, 4C -> mem[0]=0x08410005 (mov r1,#5); load_done=1, cpu_rst=0 one cycle after the 4C byte is accepted; words_loaded=1; rd_addr=0 gives 0x08410005.
- start; header 00 -> ERR, load_err=1, cpu_rst=1, in_ready=0; next start clears load_err and enters HDR. Repeat with header 11 (hex, N=17) -> same response.
- Load of 2 words with a wrong checksum byte (correct XOR ^ 01) -> ERR, load_done=0. Both words are still readable at addr 0 and 1.
- in_valid toggled every other cycle during a 3-word load -> identical memory contents and done timing relative to the last accepted byte; in_ready steady high throughout.
- rst asserted asynchronously (mid-cycle) after 6 data bytes of a 2-word load -> immediately IDLE, cpu_rst=1, words_loaded=0. mem[0] retains the written word; mem[1] is unchanged.
- In DONE, pulse start together with in_valid=1, in_data=02 -> byte not accepted; state HDR, cpu_rst=1, load_done=0; the following 02 is taken as the header.

Source files
------------

// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// memory geometry defaults and the processor's instruction field positions.
// No ports; imported by the loader RTL and by anything decoding fetched words.
package inst_loader_pkg;

   localparam int DEPTH = 16;            // instruction words
   localparam int AW    = 4;             // log2(DEPTH)
   localparam int IW    = 32;            // instruction width
   localparam int BPW   = IW / 8;        // bytes per instruction word
   localparam int BIW   = $clog2(BPW);   // byte index width

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_DATA = 3'd2,
      ST_CSUM = 3'd3,
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } state_t;

   // Instruction field positions as the processor decodes them.
   // rsrc2 and isrc overlap; mode selects which one the processor uses.
   localparam int OP_TYPE_MSB = 31, OP_TYPE_LSB = 27;
   localparam int RDST_MSB    = 26, RDST_LSB    = 22;
   localparam int RSRC1_MSB   = 21, RSRC1_LSB   = 17;
   localparam int MODE_BIT    = 16;
   localparam int RSRC2_MSB   = 15, RSRC2_LSB   = 11;
   localparam int ISRC_MSB    = 15, ISRC_LSB    = 0;

   function automatic logic [4:0] op_type_of(input logic [IW-1:0] w);
      return w[OP_TYPE_MSB:OP_TYPE_LSB];
   endfunction

   function automatic logic [4:0] rdst_of(input logic [IW-1:0] w);
      return w[RDST_MSB:RDST_LSB];
   endfunction

   function automatic logic [4:0] rsrc1_of(input logic [IW-1:0] w);
      return w[RSRC1_MSB:RSRC1_LSB];
   endfunction

   function automatic logic mode_of(input logic [IW-1:0] w);
      return w[MODE_BIT];
   endfunction

   function automatic logic [4:0] rsrc2_of(input logic [IW-1:0] w);
      return w[RSRC2_MSB:RSRC2_LSB];
   endfunction

   function automatic logic [15:0] isrc_of(input logic [IW-1:0] w);
      return w[ISRC_MSB:ISRC_LSB];
   endfunction

endpackage

// File: rtl/inst_mem_loader_if.sv
// Loader bus: host byte stream in, processor fetch port, status out.
// slave  = loader side (accepts bytes, serves fetches, drives status).
// master = host/processor side.
interface inst_mem_loader_if;
   import inst_loader_pkg::*;

   logic          start;         // one-cycle pulse, begins a load session
   logic          in_valid;      // host byte valid
   logic [7:0]    in_data;       // host byte
   logic          in_ready;      // loader accepts a byte this cycle
   logic [AW-1:0] rd_addr;       // processor fetch address
   logic [IW-1:0] rd_data;       // mem[rd_addr], combinational
   logic          cpu_rst;       // processor reset, low only when loaded
   logic          load_done;     // program loaded and verified
   logic          load_err;      // sticky header/checksum error
   logic [AW:0]   words_loaded;  // words written in this session

   modport slave (
      input  start, in_valid, in_data, rd_addr,
      output in_ready, rd_data, cpu_rst, load_done, load_err, words_loaded
   );

   modport master (
      output start, in_valid, in_data, rd_addr,
      input  in_ready, rd_data, cpu_rst, load_done, load_err, words_loaded
   );

endinterface

// File: rtl/inst_mem_loader_word_assembler.sv
// Packs an MSB-first byte stream into IW-bit words and keeps a running XOR of every byte.
// Latency: word_vld/word_dat are combinational on the BPW-th byte so the write lands on that edge.
// Backpressure: none here; the caller only presents byte_vld for bytes it has accepted.
// Ports: clk, rst (async high), clr (session restart), byte_vld/byte_dat in,
//        word_vld/word_dat out, csum (XOR of all bytes since clr).
module loader_word_assembler
   import inst_loader_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          byte_vld,
   input  logic [7:0]    byte_dat,
   output logic          word_vld,
   output logic [IW-1:0] word_dat,
   output logic [7:0]    csum
);

   logic [IW-9:0]  shift;     // the first BPW-1 bytes of the word in flight
   logic [BIW-1:0] byte_idx;

   assign word_vld = byte_vld && (byte_idx == BIW'(BPW - 1));
   assign word_dat = {shift, byte_dat};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift    <= '0;
         byte_idx <= '0;
         csum     <= '0;
      end else if (clr) begin
         shift    <= '0;
         byte_idx <= '0;
         csum     <= '0;
      end else if (byte_vld) begin
         // Stale bytes from the previous word shift out before they are used.
         shift    <= {shift[IW-17:0], byte_dat};
         csum     <= csum ^ byte_dat;
         byte_idx <= word_vld ? '0 : byte_idx + 1'b1;
      end
   end

endmodule

// File: rtl/inst_mem_loader.sv
// Loads a header/data/checksum byte stream into a DEPTH x IW instruction memory and
// holds the processor in reset until a verified program is present.
// Latency: each word is written on the edge accepting its last byte; cpu_rst drops the cycle after the checksum byte.
// Backpressure: in_ready depends on state only (high in HDR/DATA/CSUM); gaps in in_valid are allowed anywhere.
// Ports: clk, rst (async high), bus (slave: start, in_valid/in_data/in_ready,
//        rd_addr/rd_data fetch port, cpu_rst, load_done, load_err, words_loaded).
module inst_mem_loader
   import inst_loader_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   inst_mem_loader_if.slave bus
);

   state_t        state;
   logic          in_ready_q;
   logic          cpu_rst_q;
   logic          load_done_q;
   logic          load_err_q;
   logic [AW:0]   words_loaded_q;
   logic [AW:0]   n_words;
   logic [AW-1:0] addr;

   logic [IW-1:0] mem [DEPTH];

   logic          accept;
   logic          hdr_ok;
   logic          asm_clr;
   logic          asm_vld;
   logic          word_vld;
   logic [IW-1:0] word_dat;
   logic [7:0]    csum;

   assign accept  = bus.in_valid & in_ready_q;
   assign hdr_ok  = (bus.in_data != 8'd0) && (bus.in_data <= 8'(DEPTH));
   assign asm_clr = accept && (state == ST_HDR) && hdr_ok;
   assign asm_vld = accept && (state == ST_DATA);

   loader_word_assembler u_asm (
      .clk      (clk),
      .rst      (rst),
      .clr      (asm_clr),
      .byte_vld (asm_vld),
      .byte_dat (bus.in_data),
      .word_vld (word_vld),
      .word_dat (word_dat),
      .csum     (csum)
   );

   // Outputs are registered alongside state so in_ready never depends on in_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_IDLE;
         in_ready_q     <= 1'b0;
         cpu_rst_q      <= 1'b1;
         load_done_q    <= 1'b0;
         load_err_q     <= 1'b0;
         words_loaded_q <= '0;
         n_words        <= '0;
         addr           <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  state      <= ST_HDR;
                  in_ready_q <= 1'b1;
                  load_err_q <= 1'b0;
               end
            end
            ST_HDR: begin
               if (accept) begin
                  if (hdr_ok) begin
                     n_words        <= bus.in_data[AW:0];
                     addr           <= '0;
                     words_loaded_q <= '0;
                     state          <= ST_DATA;
                  end else begin
                     state      <= ST_ERR;
                     in_ready_q <= 1'b0;
                     load_err_q <= 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (word_vld) begin
                  words_loaded_q <= words_loaded_q + 1'b1;
                  addr           <= addr + 1'b1;
                  if (words_loaded_q + 1'b1 == n_words)
                     state <= ST_CSUM;
               end
            end
            ST_CSUM: begin
               if (accept) begin
                  in_ready_q <= 1'b0;
                  // csum already holds every data byte; the checksum byte itself is not folded in.
                  if (bus.in_data == csum) begin
                     state       <= ST_DONE;
                     load_done_q <= 1'b1;
                     cpu_rst_q   <= 1'b0;
                  end else begin
                     state      <= ST_ERR;
                     load_err_q <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               // in_ready is low here, so a byte presented with start is dropped.
               if (bus.start) begin
                  state       <= ST_HDR;
                  in_ready_q  <= 1'b1;
                  load_done_q <= 1'b0;
                  cpu_rst_q   <= 1'b1;
               end
            end
            ST_ERR: begin
               if (bus.start) begin
                  state      <= ST_HDR;
                  in_ready_q <= 1'b1;
                  load_err_q <= 1'b0;
               end
            end
            default: begin
               state      <= ST_IDLE;
               in_ready_q <= 1'b0;
               cpu_rst_q  <= 1'b1;
            end
         endcase
      end
   end

   // Memory has no reset: a reset mid-load keeps the words already written.
   always_ff @(posedge clk) begin
      if (word_vld)
         mem[addr] <= word_dat;
   end

   assign bus.rd_data      = mem[bus.rd_addr];
   assign bus.in_ready     = in_ready_q;
   assign bus.cpu_rst      = cpu_rst_q;
   assign bus.load_done    = load_done_q;
   assign bus.load_err     = load_err_q;
   assign bus.words_loaded = words_loaded_q;

endmodule
